sram_rd_streamer: RTL and testbench

Read-side sequencer for the 64x32 dual-port (1W1R) weight/activation SRAM. On `start` it drives the SRAM read port (csb1/addr1) over a contiguous address range. It absorbs the SRAM's 1-cycle read latency and presents words on a valid/ready stream to the systolic array edge feeder. A 2-entry output buffer provides full-throughput streaming with backpressure and no dropped or duplicated words.

---
 rtl/sram_stream_pkg.sv | 14 +
 rtl/stream_skid_fifo.sv | 45 ++++
 rtl/sram_rd_streamer.sv | 121 ++++++++++++
 tb/tb_sram_rd_streamer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_pkg.sv
// rtl/sram_stream_pkg.sv - shared types and defaults for the SRAM read/write streamers
package sram_stream_pkg;

   localparam int SRAM_DW = 32;
   localparam int SRAM_AW = 6;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_e;

   typedef struct packed {
      logic [SRAM_DW-1:0] data;
      logic               last;
   } stream_beat_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - 2-entry FIFO of stream beats with push/pop/count
module stream_skid_fifo
   import sram_stream_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  stream_beat_t push_beat,
   input  logic         pop,
   output stream_beat_t head,
   output logic         empty,
   output logic [1:0]   count
);

   stream_beat_t mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   assign head  = mem[rd_ptr];
   assign empty = (count == 2'd0);

   // Push into a full FIFO is legal only with a concurrent pop: the write lands in
   // the slot being vacated, which becomes the tail once rd_ptr advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_beat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_rd_streamer.sv
// rtl/sram_rd_streamer.sv - SRAM read sequencer to valid/ready stream; SRAM_RD_STALL_CNT_EN adds stall_cycles
module sram_rd_streamer
   import sram_stream_pkg::*;
#(
   parameter int DATA_WIDTH = SRAM_DW,
   parameter int ADDR_WIDTH = SRAM_AW,
   parameter int RD_LATENCY = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic                  csb1,
   output logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] dout1,
`ifdef SRAM_RD_STALL_CNT_EN
   output logic [31:0]           stall_cycles,
`endif
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   if (RD_LATENCY != 1 || DATA_WIDTH != SRAM_DW) begin : g_bad_cfg
      $error("sram_rd_streamer: only RD_LATENCY=1 and DATA_WIDTH=SRAM_DW are supported");
   end

   localparam logic [ADDR_WIDTH:0] REM_ONE = 1;

   rd_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH:0]   remaining_q;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic                  done_q;
   logic                  issue;
   logic                  pop;
   logic [2:0]            occupancy;
   logic [1:0]            fifo_count;
   logic                  fifo_empty;
   stream_beat_t          push_beat;
   stream_beat_t          head;

   assign pop       = m_valid & m_ready;
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
   // A pop this cycle frees a slot in time for the word issued now, which is what
   // sustains one word per cycle with the consumer ready.
   assign issue     = (state_q == ISSUE) && (occupancy < (3'd2 + {2'b00, pop}));

   assign csb1    = ~issue;
   assign addr1   = cur_addr;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign m_valid = ~fifo_empty;
   assign m_data  = head.data;
   assign m_last  = ~fifo_empty & head.last;

   assign push_beat.data = dout1;
   assign push_beat.last = inflight_last_q;

   stream_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_beat (push_beat),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && len != '0) state_d = ISSUE;
         ISSUE:   if (issue && remaining_q == REM_ONE) state_d = DRAIN;
         DRAIN:   if (pop && head.last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         cur_addr        <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         inflight_q      <= issue;
         inflight_last_q <= issue && (remaining_q == REM_ONE);
         done_q          <= (state_q == IDLE && start && len == '0) ||
                            (state_q == DRAIN && pop && head.last);
         if (state_q == IDLE && start) begin
            cur_addr    <= base_addr;
            remaining_q <= len;
         end else if (issue) begin
            cur_addr    <= cur_addr + 1'b1;
            remaining_q <= remaining_q - 1'b1;
         end
      end
   end

`ifdef SRAM_RD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= '0;
      else if (state_q == IDLE && start)
         stall_cycles <= '0;
      else if (busy && m_valid && !m_ready && stall_cycles != '1)
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_sram_rd_streamer.sv
// tb/tb_sram_rd_streamer.sv - directed self-checking bench for sram_rd_streamer
module tb_sram_rd_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  base_addr;
   logic [6:0]  len;
   logic        busy;
   logic        done;
   logic        csb1;
   logic [5:0]  addr1;
   logic [31:0] dout1;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;
`ifdef SRAM_RD_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   logic [31:0] mem [64];
   int total = 0;
   int bad   = 0;

   logic [31:0] addr_q[$];
   logic [31:0] data_q[$];
   logic        last_q[$];

   typedef struct {
      logic        start;
      logic [6:0]  len;
      logic        ready;
      logic        csb1;
      logic [5:0]  addr;
      logic        mv;
      logic [31:0] data;
      logic        last;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t vecs[13];

   always #5 clk = ~clk;

   always @(posedge clk) if (!csb1) dout1 <= mem[addr1];

   sram_rd_streamer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .csb1      (csb1),
      .addr1     (addr1),
      .dout1     (dout1),
`ifdef SRAM_RD_STALL_CNT_EN
      .stall_cycles (stall_cycles),
`endif
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic run_burst(input logic [5:0] b, input logic [6:0] n, input int toggle, input int inject_at);
      logic [31:0] pdata = 0;
      logic        pvalid = 0, pready = 1, plast = 0;
      bit          seen_done = 0;
      addr_q.delete(); data_q.delete(); last_q.delete();
      for (int c = 0; c < 80 && !seen_done; c++) begin
         @(posedge clk); #1;
         start     = (c == 0) || (c == inject_at);
         base_addr = (c == 0) ? b : 6'd20;
         len       = (c == 0) ? n : 7'd3;
         m_ready   = (toggle == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
         #4;
         if (!csb1) addr_q.push_back({26'd0, addr1});
         if (pvalid && !pready) begin
            check("stall_valid_held", m_valid, 1);
            check("stall_data_held", m_data, pdata);
            check("stall_last_held", m_last, plast);
         end
         if (m_valid && m_ready) begin
            data_q.push_back(m_data);
            last_q.push_back(m_last);
         end
         if (done) seen_done = 1;
         pvalid = m_valid; pready = m_ready; pdata = m_data; plast = m_last;
      end
      check("burst_done_seen", seen_done, 1);
      start = 0;
      m_ready = 1;
   endtask

   task automatic check_stream(input logic [5:0] b, input int n);
      check("beat_count", data_q.size(), n);
      check("addr_count", addr_q.size(), n);
      for (int i = 0; i < n && i < data_q.size() && i < addr_q.size(); i++) begin
         check("beat_data", data_q[i], 32'h100 + ((b + i) % 64));
         check("beat_last", last_q[i], (i == n - 1));
         check("issue_addr", addr_q[i], (b + i) % 64);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h100 + i;
      dout1 = 0; rst = 1; start = 0; base_addr = 0; len = 0; m_ready = 1;

      vecs[0]  = '{1'b1, 7'd8, 1'b1, 1'b1, 6'd0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 7'd8, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 7'd8, 1'b1, 1'b0, 6'd1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 7'd8, 1'b1, 1'b0, 6'd2, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 7'd8, 1'b1, 1'b0, 6'd3, 1'b1, 32'h101, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 7'd8, 1'b1, 1'b0, 6'd4, 1'b1, 32'h102, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 7'd8, 1'b1, 1'b0, 6'd5, 1'b1, 32'h103, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 7'd8, 1'b1, 1'b0, 6'd6, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 7'd8, 1'b1, 1'b0, 6'd7, 1'b1, 32'h105, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 7'd8, 1'b1, 1'b1, 6'd0, 1'b1, 32'h106, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 7'd8, 1'b1, 1'b1, 6'd0, 1'b1, 32'h107, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 7'd8, 1'b1, 1'b1, 6'd0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 7'd8, 1'b1, 1'b1, 6'd0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #5;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_csb1", csb1, 1);
      check("rst_addr1", addr1, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_last", m_last, 0);
      @(posedge clk); #1; rst = 0;

      // base=0, len=8, ready high: cycle-exact table
      for (int i = 0; i < 13; i++) begin
         @(posedge clk); #1;
         start = vecs[i].start; base_addr = 6'd0; len = vecs[i].len; m_ready = vecs[i].ready;
         #4;
         check($sformatf("t%0d_csb1", i), csb1, vecs[i].csb1);
         if (!vecs[i].csb1) check($sformatf("t%0d_addr1", i), addr1, vecs[i].addr);
         check($sformatf("t%0d_m_valid", i), m_valid, vecs[i].mv);
         if (vecs[i].mv) check($sformatf("t%0d_m_data", i), m_data, vecs[i].data);
         check($sformatf("t%0d_m_last", i), m_last, vecs[i].last);
         check($sformatf("t%0d_busy", i), busy, vecs[i].busy);
         check($sformatf("t%0d_done", i), done, vecs[i].done);
      end
      start = 0;

      // address wrap 62, 63, 0, 1
      run_burst(6'd62, 7'd4, 0, -1);
      check_stream(6'd62, 4);

      // backpressure with ready pattern 1,0,0,1
      run_burst(6'd0, 7'd8, 1, -1);
      check_stream(6'd0, 8);

      // len=0: done next cycle, no SRAM access
      @(posedge clk); #1; start = 1; len = 0; base_addr = 6'd9; #4;
      @(posedge clk); #1; start = 0; #4;
      check("len0_done", done, 1);
      check("len0_csb1", csb1, 1);
      check("len0_m_valid", m_valid, 0);
      check("len0_busy", busy, 0);
      @(posedge clk); #5;
      check("len0_done_drop", done, 0);
      check("len0_csb1_after", csb1, 1);

      // start while busy is ignored
      run_burst(6'd0, 7'd8, 0, 3);
      check_stream(6'd0, 8);
      repeat (4) begin
         @(posedge clk); #5;
         check("post_busy_m_valid", m_valid, 0);
         check("post_busy_csb1", csb1, 1);
      end

      // reset at the 4th beat of a len=16 burst
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         start = (c == 0); base_addr = 6'd0; len = 7'd16; m_ready = 1;
         rst = (c == 6);
         #4;
         if (c == 6) begin
            check("rst4_beat_valid", m_valid, 1);
            check("rst4_beat_data", m_data, 32'h103);
         end
         if (c == 7) begin
            check("rst4_m_valid", m_valid, 0);
            check("rst4_csb1", csb1, 1);
            check("rst4_busy", busy, 0);
            check("rst4_done", done, 0);
         end
      end
      repeat (3) begin
         @(posedge clk); #5;
         check("rst4_no_done", done, 0);
      end
      run_burst(6'd5, 7'd2, 0, -1);
      check_stream(6'd5, 2);

`ifdef SRAM_RD_STALL_CNT_EN
      begin
         bit sdone = 0;
         for (int c = 0; c < 40 && !sdone; c++) begin
            @(posedge clk); #1;
            start = (c == 0); base_addr = 6'd0; len = 7'd4;
            m_ready = (c >= 8);
            #4;
            if (done) sdone = 1;
         end
         start = 0;
         check("stall_done_seen", sdone, 1);
         check("stall_cycles", stall_cycles, 5);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
